rx_pair_framer: RTL

RX_PAIR_FRAMER -- requirements
Module: rx_pair_framer

---
 rtl/rx_pair_framer_pkg.sv | 22 ++
 rtl/rx_pair_framer_pair_fifo.sv | 72 +++++++
 rtl/rx_pair_framer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rx_pair_framer_pkg.sv
// rtl/rx_pair_framer_pkg.sv - shared types and constants for the pair framer
package rx_pair_framer_pkg;

    localparam int PAIR_W             = 2;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // One queued pair plus its frame markers
    typedef struct packed {
        logic              sof;
        logic              eof;
        logic [PAIR_W-1:0] pair;
    } pair_entry_t;

    localparam int ENTRY_W = $bits(pair_entry_t);

    // Waiting covers both "before first sof" and "after eof"; both discard bits
    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_IN_FRAME = 1'b1
    } frame_state_t;

endpackage

// File: rtl/rx_pair_framer_pair_fifo.sv
// rtl/rx_pair_framer_pair_fifo.sv - small registered FIFO holding assembled pairs
module pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count_q != '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer, occupancy and storage update; pointers wrap naturally at DEPTH
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rx_pair_framer.sv
// rtl/rx_pair_framer.sv - serial bit to symbol-pair framer with output FIFO
module rx_pair_framer
    import rx_pair_framer_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int LEN_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_bit,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    input  logic [LEN_W-1:0]  frame_len,
    output logic [PAIR_W-1:0] rx_pair,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic              sync_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    frame_state_t     state_q, state_d;
    logic             phase_q, phase_d;
    logic             first_bit_q, first_bit_d;
    logic [LEN_W-1:0] pair_cnt_q, pair_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             sync_err_q, sync_err_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic             is_last;
    logic             push;
    logic             pop;
    pair_entry_t      push_entry;
    pair_entry_t      head;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] occ_d;

    assign accept   = in_valid && in_ready_q;
    // A latched length of 0 makes the last index all-ones, i.e. 2^LEN_W pairs
    assign is_last  = (pair_cnt_q == (len_q - 1'b1));
    assign pop      = out_valid && out_ready;
    assign in_ready = in_ready_q;
    assign sync_err = sync_err_q;
    assign rx_pair  = head.pair;
    assign out_sof  = head.sof;
    assign out_eof  = head.eof;

    // State register plus framing datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_SOF;
            phase_q     <= 1'b0;
            first_bit_q <= 1'b0;
            pair_cnt_q  <= '0;
            len_q       <= '0;
            sync_err_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            first_bit_q <= first_bit_d;
            pair_cnt_q  <= pair_cnt_d;
            len_q       <= len_d;
            sync_err_q  <= sync_err_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next state: sof always (re)enters a frame, the eof pair leaves it
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (in_sof) begin
                state_d = ST_IN_FRAME;
            end else if ((state_q == ST_IN_FRAME) && phase_q && is_last) begin
                state_d = ST_WAIT_SOF;
            end
        end
    end

    // Pair assembly, FIFO push and sync error generation
    always_comb begin
        phase_d     = phase_q;
        first_bit_d = first_bit_q;
        pair_cnt_d  = pair_cnt_q;
        len_d       = len_q;
        sync_err_d  = 1'b0;
        push        = 1'b0;
        push_entry  = '0;
        if (accept) begin
            if (in_sof) begin
                sync_err_d  = phase_q;
                phase_d     = 1'b1;
                first_bit_d = in_bit;
                pair_cnt_d  = '0;
                len_d       = frame_len;
            end else if (state_q == ST_IN_FRAME) begin
                if (!phase_q) begin
                    phase_d     = 1'b1;
                    first_bit_d = in_bit;
                end else begin
                    push            = 1'b1;
                    push_entry.sof  = (pair_cnt_q == '0);
                    push_entry.eof  = is_last;
                    push_entry.pair = {first_bit_q, in_bit};
                    phase_d         = 1'b0;
                    pair_cnt_d      = pair_cnt_q + 1'b1;
                end
            end
        end
    end

    // Ready for next cycle from next occupancy; holding a half pair reserves a slot
    always_comb begin
        occ_d = fifo_count;
        case ({push, pop})
            2'b10:   occ_d = fifo_count + 1'b1;
            2'b01:   occ_d = fifo_count - 1'b1;
            default: occ_d = fifo_count;
        endcase
        in_ready_d = (occ_d != CNT_W'(FIFO_DEPTH)) &&
                     !((occ_d == CNT_W'(FIFO_DEPTH - 1)) && phase_d);
    end

    pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_pair_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .valid (out_valid),
        .count (fifo_count)
    );

endmodule
